note_sequencer: RTL and testbench

Programmable melody controller that replaces hard-coded pitch/duration tables. Holds a small note memory written by a host or boot loader. On start, it steps through the entries, driving the sine clock divider's maxval, a divider restart strobe and a tone gate. Durations are counted in sample ticks derived from clk, so tempo is independent of pitch.

---
 rtl/note_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_note_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// Programmable melody sequencer: steps a note memory, drives the sine divider maxval and tone gate.
// Optional articulation gap is enabled by defining ARTIC_GAP_EN.
module note_sequencer #(
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned DUR_W    = 13,
    parameter int unsigned DIV_W    = 5,
    parameter int unsigned TICK_DIV = 125,
    parameter int unsigned GAP      = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [3:0]       wr_pitch,
    input  logic [DUR_W-1:0] wr_dur,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    input  logic [AW-1:0]    last_idx,
    output logic [DIV_W-1:0] div_maxval,
    output logic             div_restart,
    output logic             tone_on,
    output logic [AW-1:0]    note_idx,
    output logic             busy,
    output logic             done
);

    localparam int unsigned TW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned ENTRY_W = 4 + DUR_W;
    localparam logic [DIV_W-1:0] SILENT_MAXVAL = DIV_W'(31);
    localparam logic [3:0]       END_CODE      = 4'd15;

`ifdef ARTIC_GAP_EN
    localparam bit GAP_ON = 1'b1;
`else
    localparam bit GAP_ON = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY,
        DONE
    } state_t;

    state_t             state;
    logic [TW-1:0]      tick_ctr;
    logic [DUR_W-1:0]   dur_ctr;
    logic [DUR_W-1:0]   dur_q;
    logic [ENTRY_W-1:0] mem [DEPTH];

    logic [3:0]         rd_pitch_c;
    logic [DUR_W-1:0]   rd_dur_c;
    logic [DUR_W-1:0]   dur_inc_c;
    logic [AW-1:0]      end_idx_c;
    logic               end_done_c;
    logic               tick_c;

    // Pitch code to divider maxval; rests and the end marker map to the silent value.
    function automatic logic [DIV_W-1:0] decode_pitch(input logic [3:0] code);
        logic [DIV_W-1:0] mv;
        case (code)
            4'd0:    mv = DIV_W'(18);
            4'd1:    mv = DIV_W'(13);
            4'd2:    mv = DIV_W'(15);
            4'd3:    mv = DIV_W'(16);
            4'd4:    mv = DIV_W'(20);
            4'd5:    mv = DIV_W'(21);
            4'd6:    mv = DIV_W'(24);
            4'd7:    mv = DIV_W'(27);
            default: mv = SILENT_MAXVAL;
        endcase
        return mv;
    endfunction

    // Note memory: written any time, never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= {wr_pitch, wr_dur};
        end
    end

    assign {rd_pitch_c, rd_dur_c} = mem[note_idx];
    assign dur_inc_c  = dur_ctr + DUR_W'(1);
    assign tick_c     = (tick_ctr == TW'(TICK_DIV - 1));
    assign end_done_c = (note_idx == last_idx) && !loop_en;
    assign end_idx_c  = ((note_idx == last_idx) || (note_idx == AW'(DEPTH - 1)))
                        ? '0 : note_idx + AW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            div_maxval  <= SILENT_MAXVAL;
            div_restart <= 1'b0;
            tone_on     <= 1'b0;
            note_idx    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            tick_ctr    <= '0;
            dur_ctr     <= '0;
            dur_q       <= '0;
        end else begin
            div_restart <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state    <= LOAD;
                        note_idx <= '0;
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (stop) begin
                        state      <= IDLE;
                        tone_on    <= 1'b0;
                        div_maxval <= SILENT_MAXVAL;
                        busy       <= 1'b0;
                    end else if (rd_pitch_c == END_CODE) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        tone_on    <= 1'b0;
                        div_maxval <= SILENT_MAXVAL;
                    end else if (rd_dur_c == '0) begin
                        // Zero-length entry: advance without touching the divider.
                        if (end_done_c) begin
                            state      <= DONE;
                            done       <= 1'b1;
                            tone_on    <= 1'b0;
                            div_maxval <= SILENT_MAXVAL;
                        end else begin
                            note_idx <= end_idx_c;
                        end
                    end else begin
                        state       <= PLAY;
                        dur_q       <= rd_dur_c;
                        div_maxval  <= decode_pitch(rd_pitch_c);
                        div_restart <= 1'b1;
                        tone_on     <= ~rd_pitch_c[3];
                        tick_ctr    <= '0;
                        dur_ctr     <= '0;
                    end
                end
                PLAY: begin
                    if (stop) begin
                        state      <= IDLE;
                        tone_on    <= 1'b0;
                        div_maxval <= SILENT_MAXVAL;
                        busy       <= 1'b0;
                    end else if (tick_c) begin
                        tick_ctr <= '0;
                        dur_ctr  <= dur_inc_c;
                        if (dur_inc_c == dur_q) begin
                            tone_on <= 1'b0;
                            if (end_done_c) begin
                                state      <= DONE;
                                done       <= 1'b1;
                                div_maxval <= SILENT_MAXVAL;
                            end else begin
                                state    <= LOAD;
                                note_idx <= end_idx_c;
                            end
                        end else if (GAP_ON && (dur_q > DUR_W'(GAP))
                                     && (dur_inc_c == dur_q - DUR_W'(GAP))) begin
                            tone_on <= 1'b0;
                        end
                    end else begin
                        tick_ctr <= tick_ctr + TW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed melody scenarios with literal expectations plus
// randomized traffic checked every cycle against a cycle-count behavioural model.
module tb_note_sequencer;

    localparam int TD    = 4;
    localparam int GAP_T = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [3:0]  wr_pitch = '0;
    logic [12:0] wr_dur = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic [4:0]  last_idx = '0;
    logic [4:0]  div_maxval;
    logic        div_restart;
    logic        tone_on;
    logic [4:0]  note_idx;
    logic        busy;
    logic        done;

    note_sequencer #(.TICK_DIV(TD), .GAP(GAP_T)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_pitch(wr_pitch), .wr_dur(wr_dur), .start(start), .stop(stop),
        .loop_en(loop_en), .last_idx(last_idx), .div_maxval(div_maxval),
        .div_restart(div_restart), .tone_on(tone_on), .note_idx(note_idx),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a note is a block of dur*TD cycles after one load cycle.
    typedef enum {M_IDLE, M_LOAD, M_PLAY, M_DONE} mmode_t;
    mmode_t     mode = M_IDLE;
    int         tab [8] = '{18, 13, 15, 16, 20, 21, 24, 27};
    logic [3:0] mp [32];
    logic [12:0] md [32];
    int         e_maxval = 31, e_restart = 0, e_tone = 0, e_busy = 0, e_done = 0;
    logic [4:0] e_idx = '0;
    int         m_el = 0, m_len = 0, m_silent = 0, m_p = 0, m_d = 0;

    task automatic m_finish();
        mode = M_DONE; e_done = 1; e_tone = 0; e_maxval = 31;
    endtask

    task automatic m_next();
        if (e_idx == last_idx) begin
            if (loop_en) begin e_idx = 5'd0; mode = M_LOAD; end
            else m_finish();
        end else begin
            e_idx = e_idx + 5'd1;
            mode = M_LOAD;
        end
    endtask

    task automatic m_abort();
        mode = M_IDLE; e_tone = 0; e_maxval = 31; e_busy = 0;
    endtask

    always @(posedge clk) begin
        e_restart = 0;
        e_done = 0;
        if (reset) begin
            mode = M_IDLE; e_maxval = 31; e_tone = 0; e_idx = '0; e_busy = 0;
        end else begin
            case (mode)
                M_IDLE: if (start && !stop) begin mode = M_LOAD; e_idx = '0; e_busy = 1; end
                M_LOAD: begin
                    m_p = int'(mp[e_idx]);
                    m_d = int'(md[e_idx]);
                    if (stop) m_abort();
                    else if (m_p == 15) m_finish();
                    else if (m_d == 0) m_next();
                    else begin
                        e_restart = 1;
                        e_maxval = (m_p < 8) ? tab[m_p] : 31;
                        e_tone = (m_p < 8) ? 1 : 0;
                        m_len = m_d * TD;
`ifdef ARTIC_GAP_EN
                        m_silent = (m_d > GAP_T) ? (m_d - GAP_T) * TD : m_len;
`else
                        m_silent = m_len;
`endif
                        m_el = 0;
                        mode = M_PLAY;
                    end
                end
                M_PLAY: begin
                    if (stop) m_abort();
                    else begin
                        m_el++;
                        if (m_el == m_silent) e_tone = 0;
                        if (m_el == m_len) begin e_tone = 0; m_next(); end
                    end
                end
                M_DONE: begin mode = M_IDLE; e_busy = 0; end
                default: mode = M_IDLE;
            endcase
        end
        if (wr_en) begin
            mp[wr_addr] = wr_pitch;
            md[wr_addr] = wr_dur;
        end
    end

    // Cycle-by-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("div_maxval", int'(div_maxval), e_maxval);
            check("div_restart", int'(div_restart), e_restart);
            check("tone_on", int'(tone_on), e_tone);
            check("note_idx", int'(note_idx), int'(e_idx));
            check("busy", int'(busy), e_busy);
            check("done", int'(done), e_done);
        end
    end

    int r_max [64], r_rst [64], r_tone [64], r_idx [64], r_busy [64], r_done [64];

    task automatic write_entry(input int a, input int p, input int d);
        wr_en = 1'b1; wr_addr = 5'(a); wr_pitch = 4'(p); wr_dur = 13'(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Samples outputs for n cycles; optional extra start/stop pulses at given samples.
    task automatic run_window(input int n, input int s_at, input int p_at);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            r_max[i] = int'(div_maxval); r_rst[i] = int'(div_restart);
            r_tone[i] = int'(tone_on); r_idx[i] = int'(note_idx);
            r_busy[i] = int'(busy); r_done[i] = int'(done);
            start = (i == s_at);
            stop = (i == p_at);
        end
        start = 1'b0;
        stop = 1'b0;
    endtask

    function automatic int n_rst(input int n);
        int c = 0;
        for (int i = 1; i <= n; i++) c += r_rst[i];
        return c;
    endfunction

    function automatic int n_done(input int n);
        int c = 0;
        for (int i = 1; i <= n; i++) c += r_done[i];
        return c;
    endfunction

    function automatic int n_tone(input int n);
        int c = 0;
        for (int i = 1; i <= n; i++) c += r_tone[i];
        return c;
    endfunction

    initial begin
        int c;
        idle(2);
        chk_en = 1'b1;
        check("rst_maxval", int'(div_maxval), 31);
        check("rst_busy", int'(busy), 0);
        check("rst_idx", int'(note_idx), 0);
        check("rst_tone", int'(tone_on), 0);
        reset = 1'b0;
        for (int a = 0; a < 32; a++) write_entry(a, 0, 1);

        // Melody A(3), Dhigh(2), D(1); a start mid-note must be ignored.
        write_entry(0, 0, 3);
        write_entry(1, 1, 2);
        write_entry(2, 7, 1);
        last_idx = 5'd2; loop_en = 1'b0;
        start = 1'b1;
        run_window(40, 8, 0);
        check("s1_restarts", n_rst(40), 3);
        check("s1_rst2", r_rst[2], 1);   check("s1_max2", r_max[2], 18);
        check("s1_rst15", r_rst[15], 1); check("s1_max15", r_max[15], 13);
        check("s1_rst24", r_rst[24], 1); check("s1_max24", r_max[24], 27);
        check("s1_max13", r_max[13], 18);
        check("s1_done_cnt", n_done(40), 1);
        check("s1_done28", r_done[28], 1);
        check("s1_busy28", r_busy[28], 1);
        check("s1_busy29", r_busy[29], 0);
        check("s1_max29", r_max[29], 31);
        check("s1_tone9", r_tone[9], 1);
`ifdef ARTIC_GAP_EN
        check("s1_tone_cnt", n_tone(40), 16);
        check("s1_tone10", r_tone[10], 0);
`else
        check("s1_tone_cnt", n_tone(40), 24);
        check("s1_tone10", r_tone[10], 1);
`endif

        // Looping, then stop in the middle of a note.
        loop_en = 1'b1;
        start = 1'b1;
        run_window(34, 0, 31);
        check("s2_restarts", n_rst(34), 4);
        check("s2_rst29", r_rst[29], 1);
        check("s2_max29", r_max[29], 18);
        check("s2_idx29", r_idx[29], 0);
        check("s2_done_cnt", n_done(34), 0);
        check("s2_busy31", r_busy[31], 1);
        check("s2_busy32", r_busy[32], 0);
        check("s2_tone32", r_tone[32], 0);
        check("s2_max32", r_max[32], 31);
        check("s2_busy34", r_busy[34], 0);
        loop_en = 1'b0;
        idle(2);

        // start and stop together stay idle.
        start = 1'b1; stop = 1'b1;
        run_window(5, 0, 0);
        check("ss_restarts", n_rst(5), 0);
        check("ss_busy1", r_busy[1], 0);
        check("ss_busy5", r_busy[5], 0);

        // Rest and zero-duration skip.
        write_entry(1, 9, 2);
        write_entry(2, 0, 0);
        write_entry(3, 7, 1);
        last_idx = 5'd3;
        start = 1'b1;
        run_window(32, 0, 0);
        check("s3_restarts", n_rst(32), 3);
        check("s3_rst15", r_rst[15], 1);
        check("s3_rst25", r_rst[25], 1);
        check("s3_max25", r_max[25], 27);
        check("s3_idx24", r_idx[24], 3);
        check("s3_done29", r_done[29], 1);
        c = 0;
        for (int i = 15; i <= 22; i++) if (r_tone[i] == 0 && r_max[i] == 31) c++;
        check("s3_rest_cycles", c, 8);
`ifdef ARTIC_GAP_EN
        check("s3_tone_cnt", n_tone(32), 12);
`else
        check("s3_tone_cnt", n_tone(32), 16);
`endif

        // End marker stops playback early.
        write_entry(1, 15, 0);
        last_idx = 5'd4;
        start = 1'b1;
        run_window(20, 0, 0);
        check("s4_restarts", n_rst(20), 1);
        check("s4_done_cnt", n_done(20), 1);
        check("s4_done15", r_done[15], 1);
        check("s4_idx15", r_idx[15], 1);
        check("s4_busy16", r_busy[16], 0);

        // Reset in the middle of a note.
        write_entry(1, 1, 2);
        start = 1'b1;
        run_window(6, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        check("rmid_busy", int'(busy), 0);
        check("rmid_maxval", int'(div_maxval), 31);
        check("rmid_tone", int'(tone_on), 0);
        check("rmid_idx", int'(note_idx), 0);
        reset = 1'b0;
        idle(2);

        // Randomized traffic checked by the model.
        for (int i = 0; i < 4000; i++) begin
            wr_en = ($urandom_range(7) == 0);
            wr_addr = 5'($urandom_range(31));
            wr_pitch = ($urandom_range(9) == 0) ? 4'd15 : 4'($urandom_range(14));
            wr_dur = 13'($urandom_range(3));
            start = ($urandom_range(19) == 0);
            stop = ($urandom_range(99) == 0);
            reset = ($urandom_range(499) == 0);
            if ($urandom_range(49) == 0) loop_en = 1'($urandom_range(1));
            if ($urandom_range(29) == 0) last_idx = 5'($urandom_range(31));
            @(negedge clk);
        end
        wr_en = 1'b0; start = 1'b0; stop = 1'b0; reset = 1'b0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
